// File: rtl/irq_controller_if.sv
// Request/acknowledge link between the interrupt controller and the CPU control path.
interface irq_controller_if #(
    parameter int unsigned VECTOR_WIDTH = 16
);
    logic                    irq;
    logic [VECTOR_WIDTH-1:0] irq_vector;
    logic                    irq_ack;
    logic                    irq_return;

    modport master (
        input  irq,
        input  irq_vector,
        output irq_ack,
        output irq_return
    );

    modport slave (
        output irq,
        output irq_vector,
        input  irq_ack,
        input  irq_return
    );
endinterface

// File: rtl/irq_controller.sv
// Prioritised, nestable interrupt controller driving the control path's single irq request.
// Edge/level capture, enable mask, fixed priority and an active-priority stack for nesting.
module irq_controller #(
    parameter int unsigned              NUM_IRQ       = 8,
    parameter int unsigned              VECTOR_WIDTH  = 16,
    parameter logic [VECTOR_WIDTH-1:0]  VECTOR_BASE   = 16'hFF00,
    parameter int unsigned              VECTOR_STRIDE = 2,
    parameter logic [NUM_IRQ-1:0]       EDGE_MASK     = '1,
    parameter int unsigned              MAX_NEST      = 4,
    localparam int unsigned             IDX_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int unsigned             DEPTH_W       = $clog2(MAX_NEST + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic               mask_write,
    input  logic [NUM_IRQ-1:0] mask_data,
    irq_controller_if.slave    cpu,
    output logic [NUM_IRQ-1:0] enable,
    output logic [NUM_IRQ-1:0] pending,
    output logic [DEPTH_W-1:0] nest_depth,
    output logic               spurious
);

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_IRQ-1:0]      line_q, line_d;
    logic [NUM_IRQ-1:0]      pending_q, pending_d;
    logic [NUM_IRQ-1:0]      enable_q, enable_d;
    logic                    irq_q, irq_d;
    logic [VECTOR_WIDTH-1:0] vector_q, vector_d;
    logic [IDX_W-1:0]        chan_q, chan_d;
    logic [IDX_W-1:0]        stack_q [MAX_NEST];
    logic [IDX_W-1:0]        stack_d [MAX_NEST];
    logic [DEPTH_W-1:0]      depth_q, depth_d;
    logic                    spurious_q, spurious_d;

    logic [NUM_IRQ-1:0]      set_vec;
    logic [NUM_IRQ-1:0]      clear_vec;
    logic [NUM_IRQ-1:0]      candidates;
    logic [IDX_W-1:0]        top_idx;
    logic                    stack_empty;
    logic                    stack_full;
    logic                    elig_valid;
    logic [IDX_W-1:0]        elig_idx;
    logic [VECTOR_WIDTH-1:0] elig_vector;

    // Eligibility: lowest pending&enabled channel that outranks the in-service top.
    always_comb begin
        line_d      = irq_lines;
        set_vec     = irq_lines & (~EDGE_MASK | ~line_q);
        stack_empty = (depth_q == '0);
        stack_full  = (depth_q >= DEPTH_W'(MAX_NEST));
        top_idx     = '0;
        for (int unsigned i = 0; i < MAX_NEST; i++) begin
            if (!stack_empty && (DEPTH_W'(i) == depth_q - DEPTH_W'(1))) begin
                top_idx = stack_q[i];
            end
        end
        candidates = pending_q & enable_q;
        elig_valid = 1'b0;
        elig_idx   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!elig_valid && candidates[i] && (stack_empty || (IDX_W'(i) < top_idx))) begin
                elig_valid = 1'b1;
                elig_idx   = IDX_W'(i);
            end
        end
        if (stack_full) begin
            elig_valid = 1'b0;
        end
        elig_vector = VECTOR_WIDTH'(32'(VECTOR_BASE) + 32'(elig_idx) * VECTOR_STRIDE);
    end

    // Return is applied before a same-cycle ack so the push lands on the popped slot.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        irq_d      = irq_q;
        vector_d   = vector_q;
        enable_d   = mask_write ? mask_data : enable_q;
        spurious_d = spurious_q;
        stack_d    = stack_q;
        depth_d    = depth_q;
        clear_vec  = '0;

        if (cpu.irq_return) begin
            if (stack_empty) begin
                spurious_d = 1'b1;
            end else begin
                depth_d = depth_q - DEPTH_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (cpu.irq_ack) begin
                    spurious_d = 1'b1;
                end
                if (elig_valid) begin
                    state_d  = ST_REQ;
                    chan_d   = elig_idx;
                    vector_d = elig_vector;
                    irq_d    = 1'b1;
                end
            end
            ST_REQ: begin
                irq_d = 1'b1;
                if (cpu.irq_ack) begin
                    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                        if (IDX_W'(i) == chan_q) begin
                            clear_vec[i] = 1'b1;
                        end
                    end
                    for (int unsigned i = 0; i < MAX_NEST; i++) begin
                        if (DEPTH_W'(i) == depth_d) begin
                            stack_d[i] = chan_q;
                        end
                    end
                    depth_d = depth_d + DEPTH_W'(1);
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase

        pending_d = (pending_q & ~clear_vec) | set_vec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            irq_q      <= 1'b0;
            vector_q   <= '0;
            chan_q     <= '0;
            depth_q    <= '0;
            spurious_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_NEST; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            irq_q      <= irq_d;
            vector_q   <= vector_d;
            chan_q     <= chan_d;
            depth_q    <= depth_d;
            spurious_q <= spurious_d;
            for (int unsigned i = 0; i < MAX_NEST; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign cpu.irq        = irq_q;
    assign cpu.irq_vector = vector_q;
    assign enable         = enable_q;
    assign pending        = pending_q;
    assign nest_depth     = depth_q;
    assign spurious       = spurious_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: channel 1 level-triggered, stack depth 2.
module tb_irq_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq_lines = '0;
    logic       mask_write = 1'b0;
    logic [7:0] mask_data = '0;
    logic [7:0] enable;
    logic [7:0] pending;
    logic [1:0] nest_depth;
    logic       spurious;

    int checks = 0;
    int failures = 0;

    irq_controller_if #(.VECTOR_WIDTH(16)) cpu_if ();

    irq_controller #(
        .NUM_IRQ      (8),
        .VECTOR_WIDTH (16),
        .VECTOR_BASE  (16'hFF00),
        .VECTOR_STRIDE(2),
        .EDGE_MASK    (8'hFD),
        .MAX_NEST     (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .irq_lines (irq_lines),
        .mask_write(mask_write),
        .mask_data (mask_data),
        .cpu       (cpu_if.slave),
        .enable    (enable),
        .pending   (pending),
        .nest_depth(nest_depth),
        .spurious  (spurious)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        irq_lines = '0;
        mask_write = 1'b0;
        mask_data = '0;
        cpu_if.irq_ack = 1'b0;
        cpu_if.irq_return = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_write = 1'b1;
        mask_data = m;
        tick();
        mask_write = 1'b0;
    endtask

    task automatic ack();
        cpu_if.irq_ack = 1'b1;
        tick();
        cpu_if.irq_ack = 1'b0;
    endtask

    task automatic ret();
        cpu_if.irq_return = 1'b1;
        tick();
        cpu_if.irq_return = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cpu_if.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0h want=0", cpu_if.irq); end
        checks++; if (cpu_if.irq_vector !== 16'h0000) begin failures++; $display("FAIL reset_vector got=%0h want=0", cpu_if.irq_vector); end
        checks++; if (enable !== 8'h00) begin failures++; $display("FAIL reset_enable got=%0h want=0", enable); end
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%0h want=0", pending); end
        checks++; if (nest_depth !== 2'd0) begin failures++; $display("FAIL reset_depth got=%0d want=0", nest_depth); end
        checks++; if (spurious !== 1'b0) begin failures++; $display("FAIL reset_spurious got=%0h want=0", spurious); end
    endtask

    task automatic test_single();
        set_mask(8'h01);
        checks++; if (enable !== 8'h01) begin failures++; $display("FAIL single_enable got=%0h want=01", enable); end
        irq_lines = 8'h01;
        tick();
        checks++; if (pending !== 8'h01) begin failures++; $display("FAIL single_pending got=%0h want=01", pending); end
        checks++; if (cpu_if.irq !== 1'b0) begin failures++; $display("FAIL single_irq_early got=%0h want=0", cpu_if.irq); end
        tick();
        checks++; if (cpu_if.irq !== 1'b1) begin failures++; $display("FAIL single_irq got=%0h want=1", cpu_if.irq); end
        checks++; if (cpu_if.irq_vector !== 16'hFF00) begin failures++; $display("FAIL single_vector got=%0h want=ff00", cpu_if.irq_vector); end
        ack();
        checks++; if (cpu_if.irq !== 1'b0) begin failures++; $display("FAIL single_ack_irq got=%0h want=0", cpu_if.irq); end
        checks++; if (nest_depth !== 2'd1) begin failures++; $display("FAIL single_ack_depth got=%0d want=1", nest_depth); end
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL single_ack_pending got=%0h want=0", pending); end
        irq_lines = 8'h00;
        ret();
        checks++; if (nest_depth !== 2'd0) begin failures++; $display("FAIL single_ret_depth got=%0d want=0", nest_depth); end
    endtask

    task automatic test_priority();
        set_mask(8'hFF);
        irq_lines = 8'h28;
        tick();
        irq_lines = 8'h00;
        checks++; if (pending !== 8'h28) begin failures++; $display("FAIL prio_pending got=%0h want=28", pending); end
        tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF06 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL prio_first got=%0h/%0h want=1/ff06", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        checks++; if (pending !== 8'h20) begin failures++; $display("FAIL prio_ack_pending got=%0h want=20", pending); end
        tick();
        checks++; if (cpu_if.irq !== 1'b0) begin failures++; $display("FAIL prio_blocked got=%0h want=0", cpu_if.irq); end
        ret();
        checks++; if (cpu_if.irq !== 1'b0 || nest_depth !== 2'd0) begin failures++; $display("FAIL prio_ret got=%0h/%0d want=0/0", cpu_if.irq, nest_depth); end
        tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF0A || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL prio_second got=%0h/%0h want=1/ff0a", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        ret();
        checks++; if (nest_depth !== 2'd0) begin failures++; $display("FAIL prio_end_depth got=%0d want=0", nest_depth); end
    endtask

    task automatic test_nesting();
        irq_lines = 8'h10; tick(); irq_lines = 8'h00; tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF08 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL nest_ch4 got=%0h/%0h want=1/ff08", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        irq_lines = 8'h04; tick(); irq_lines = 8'h00; tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF04 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL nest_ch2 got=%0h/%0h want=1/ff04", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        checks++; if (nest_depth !== 2'd2) begin failures++; $display("FAIL nest_depth2 got=%0d want=2", nest_depth); end
        irq_lines = 8'h40; tick(); irq_lines = 8'h00; tick();
        checks++; if (cpu_if.irq !== 1'b0 || pending !== 8'h40) begin failures++; $display("FAIL nest_ch6_held got=%0h/%0h want=0/40", cpu_if.irq, pending); end
        ret();
        tick();
        checks++; if (cpu_if.irq !== 1'b0 || nest_depth !== 2'd1) begin failures++; $display("FAIL nest_after_ret1 got=%0h/%0d want=0/1", cpu_if.irq, nest_depth); end
        ret();
        tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF0C || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL nest_ch6 got=%0h/%0h want=1/ff0c", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        ret();
    endtask

    task automatic test_stack_full();
        irq_lines = 8'h20; tick(); irq_lines = 8'h00; tick();
        ack();
        irq_lines = 8'h08; tick(); irq_lines = 8'h00; tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF06 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL full_ch3 got=%0h/%0h want=1/ff06", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        checks++; if (nest_depth !== 2'd2) begin failures++; $display("FAIL full_depth got=%0d want=2", nest_depth); end
        irq_lines = 8'h01; tick(); irq_lines = 8'h00; tick(); tick();
        checks++; if (cpu_if.irq !== 1'b0 || pending !== 8'h01) begin failures++; $display("FAIL full_blocked got=%0h/%0h want=0/01", cpu_if.irq, pending); end
        ret();
        checks++; if (cpu_if.irq !== 1'b0 || nest_depth !== 2'd1) begin failures++; $display("FAIL full_ret got=%0h/%0d want=0/1", cpu_if.irq, nest_depth); end
        tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF00 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL full_ch0 got=%0h/%0h want=1/ff00", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        ret();
        ret();
        checks++; if (nest_depth !== 2'd0) begin failures++; $display("FAIL full_end_depth got=%0d want=0", nest_depth); end
    endtask

    task automatic test_level_mask();
        set_mask(8'h00);
        irq_lines = 8'h02;
        tick();
        checks++; if (pending !== 8'h02 || cpu_if.irq !== 1'b0) begin failures++; $display("FAIL lvl_masked got=%0h/%0h want=02/0", pending, cpu_if.irq); end
        set_mask(8'h02);
        checks++; if (cpu_if.irq !== 1'b0) begin failures++; $display("FAIL lvl_mask_latency got=%0h want=0", cpu_if.irq); end
        tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF02 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL lvl_req got=%0h/%0h want=1/ff02", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        checks++; if (pending !== 8'h02 || cpu_if.irq !== 1'b0 || nest_depth !== 2'd1) begin failures++; $display("FAIL lvl_ack_reset got=%0h/%0h/%0d want=02/0/1", pending, cpu_if.irq, nest_depth); end
        ret();
        tick();
        checks++; if (cpu_if.irq !== 1'b1) begin failures++; $display("FAIL lvl_rereq got=%0h want=1", cpu_if.irq); end
        set_mask(8'h00);
        tick();
        checks++; if (cpu_if.irq !== 1'b1 || cpu_if.irq_vector !== 16'hFF02 || enable !== 8'h00) begin failures++; $display("FAIL lvl_mask_in_req got=%0h/%0h/%0h want=1/ff02/00", cpu_if.irq, cpu_if.irq_vector, enable); end
        irq_lines = 8'h00;
        ack();
        checks++; if (pending !== 8'h00 || cpu_if.irq !== 1'b0) begin failures++; $display("FAIL lvl_clear got=%0h/%0h want=00/0", pending, cpu_if.irq); end
        ret();
    endtask

    task automatic test_back_to_back();
        set_mask(8'h1C);
        irq_lines = 8'h10; tick(); irq_lines = 8'h00; tick();
        ack();
        irq_lines = 8'h04; tick(); irq_lines = 8'h00; tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF04 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL b2b_ch2 got=%0h/%0h want=1/ff04", cpu_if.irq, cpu_if.irq_vector); end
        cpu_if.irq_ack = 1'b1;
        cpu_if.irq_return = 1'b1;
        tick();
        cpu_if.irq_ack = 1'b0;
        cpu_if.irq_return = 1'b0;
        checks++; if (nest_depth !== 2'd1 || cpu_if.irq !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL b2b_swap got=%0d/%0h/%0h want=1/0/00", nest_depth, cpu_if.irq, pending); end
        irq_lines = 8'h08; tick(); irq_lines = 8'h00; tick(); tick();
        checks++; if (cpu_if.irq !== 1'b0) begin failures++; $display("FAIL b2b_top_is_ch2 got=%0h want=0", cpu_if.irq); end
        ret();
        tick();
        checks++; if (cpu_if.irq_vector !== 16'hFF06 || cpu_if.irq !== 1'b1) begin failures++; $display("FAIL b2b_ch3 got=%0h/%0h want=1/ff06", cpu_if.irq, cpu_if.irq_vector); end
        ack();
        ret();
        checks++; if (spurious !== 1'b0 || nest_depth !== 2'd0) begin failures++; $display("FAIL b2b_clean got=%0h/%0d want=0/0", spurious, nest_depth); end
    endtask

    task automatic test_errors();
        do_reset();
        ret();
        checks++; if (spurious !== 1'b1 || nest_depth !== 2'd0) begin failures++; $display("FAIL err_ret_empty got=%0h/%0d want=1/0", spurious, nest_depth); end
        tick();
        checks++; if (spurious !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0h want=1", spurious); end
        do_reset();
        ack();
        checks++; if (spurious !== 1'b1 || cpu_if.irq !== 1'b0 || nest_depth !== 2'd0 || pending !== 8'h00) begin failures++; $display("FAIL err_ack_idle got=%0h/%0h/%0d/%0h want=1/0/0/00", spurious, cpu_if.irq, nest_depth, pending); end
    endtask

    task automatic test_reset_in_req();
        do_reset();
        set_mask(8'h01);
        irq_lines = 8'h01; tick(); irq_lines = 8'h00; tick();
        checks++; if (cpu_if.irq !== 1'b1) begin failures++; $display("FAIL rst_req_setup got=%0h want=1", cpu_if.irq); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (cpu_if.irq !== 1'b0 || cpu_if.irq_vector !== 16'h0000 || enable !== 8'h00 || pending !== 8'h00 || nest_depth !== 2'd0) begin failures++; $display("FAIL rst_async got=%0h/%0h/%0h/%0h/%0d want=0/0/0/0/0", cpu_if.irq, cpu_if.irq_vector, enable, pending, nest_depth); end
        irq_lines = 8'h01;
        #5;
        reset = 1'b1;
        tick();
        checks++; if (pending !== 8'h01) begin failures++; $display("FAIL rst_edge_history got=%0h want=01", pending); end
        irq_lines = 8'h00;
    endtask

    initial begin
        cpu_if.irq_ack = 1'b0;
        cpu_if.irq_return = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_stack_full();
        test_level_mask();
        test_back_to_back();
        test_errors();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised, prioritised, nestable interrupt controller that feeds the CPU control path's single `irq` request line. It collects `NUM_IRQ` external interrupt sources (edge or level per channel), applies an enable mask and fixed priority, and presents one request at a time with a vector address for the control path's `pc_data_source::irq` path. It tracks nesting through the control path's acknowledge and return-from-interrupt pulses.

## Interface
- `NUM_IRQ`, 8: number of interrupt channels (1..16); channel 0 has highest priority.
- `VECTOR_WIDTH`, 16: width of the vector address.
- `VECTOR_BASE`, 16'hFF00: vector of channel 0.
- `VECTOR_STRIDE`, 2: address step between consecutive channel vectors.
- `EDGE_MASK`, all ones: bit i = 1 makes channel i rising-edge triggered; 0 makes it level triggered (active high).
- `MAX_NEST`, 4: depth of the active-priority stack (1..8).

Ports:
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clock is `clock`.
- `irq_lines`  in  NUM_IRQ  raw interrupt sources, already synchronous to `clock`.
- `mask_write`  in  1  load `mask_data` into the enable register this cycle.
- `mask_data`  in  NUM_IRQ  new enable value (1 = enabled).
- `irq_ack`  in  1  one-cycle pulse from the control path when it enters `op_irq_reset`.
- `irq_return`  in  1  one-cycle pulse from the control path on `rti` completion.
- `irq`  out  1  registered request to the control path.
- `irq_vector`  out  VECTOR_WIDTH  registered vector of the requested channel.
- `enable`  out  NUM_IRQ  current enable register.
- `pending`  out  NUM_IRQ  pending latches.
- `nest_depth`  out  clog2(MAX_NEST+1)  number of in-service interrupts.
- `spurious`  out  1  sticky error: ack with no request, or return with empty stack.

## Operation
- Pending: edge channel i sets `pending[i]` on the clock where `irq_lines[i]`=1 and the previous sample was 0. Level channel i sets `pending[i]` on every clock with the line high. Pending is set regardless of enable.
- Clear: `irq_ack` clears pending for the latched channel. If a set condition for the same channel occurs in the same cycle, the set wins.
- Eligible channel: the lowest index with `pending & enable` set, strictly higher priority than the top of the active stack (or any channel if the stack is empty), with `nest_depth < MAX_NEST`.
- FSM states:
  - IDLE: `irq`=0. If an eligible channel exists, latch its index, set `irq_vector` = VECTOR_BASE + index*VECTOR_STRIDE (truncated to VECTOR_WIDTH), and go to REQ.
  - REQ: `irq`=1, with vector and channel held stable. A change in mask or pending never retracts or changes the request. On `irq_ack`, push the channel onto the stack, clear its pending bit, and go to IDLE.
- `irq_return`: pop the stack. On an empty stack, ignore it and set `spurious`.
- `irq_ack` in IDLE: ignored, sets `spurious`.
- Simultaneous `irq_ack` and `irq_return` in REQ: pop first, then push. Net depth is unchanged and the top becomes the new channel.
- `mask_write` takes effect on the next clock edge. It does not affect an in-flight REQ.
- `spurious` clears only on reset.

## Timing
- Reset (asynchronous, active-low) produces:
  - FSM in IDLE.
  - `irq`=0, `irq_vector`=0, `enable`=0, `pending`=0.
  - Stack empty, `nest_depth`=0, `spurious`=0.
  - Edge history registers = 0, so a line already high at reset release counts as an edge.
- Latency:
  - Line rise sampled at edge k → `pending` high after k.
  - `irq` and `irq_vector` high after k+1, when eligible.
- `irq_ack` at edge a → `irq`=0, pending cleared, and `nest_depth`+1 after a. The next request can assert no earlier than after a+1.
- `irq_return` at edge r → `nest_depth`-1 after r. A lower-priority pending request can assert after r+1.
- Reset asserted mid-REQ drops `irq` immediately (asynchronous).

## Test plan
- **Single channel:** enable=8'h01; pulse line0 → `irq`=1 two cycles later with vector 16'hFF00; ack → `irq`=0, `nest_depth`=1, `pending`=0; return → depth 0.
- **Priority:** enable=8'hFF; raise lines 3 and 5 on the same cycle → vector 16'hFF06; after ack and return, the next request has vector 16'hFF0A.
- **Nesting:** in service ch4; raise ch2 → request with vector 16'hFF04, ack → depth 2. Raise ch6 → no request until both returns; after the second return → request 16'hFF0C.
- **Stack full:** MAX_NEST=2; nest ch5 then ch3; raise ch0 → `irq` stays 0 until a return, then request 16'hFF00.
- **Masking and level mode:**
  - EDGE_MASK bit1=0. Hold line1 high with enable=0 → `pending[1]`=1, `irq`=0. Enable bit1 → request.
  - Ack while the line is still high → pending re-sets the next cycle.
  - A mask write to 0 during REQ does not drop `irq`.
- **Errors and reset:**
  - Return with depth 0 → `spurious`=1, depth stays 0.
  - Ack in IDLE → no state change.
  - Reset asserted during REQ → all outputs 0 immediately.
